// File: rtl/ofs_plat_reset_seq_pkg.sv
// ofs_plat_reset_seq_pkg
//   Shared types and constants for the reset release sequencer.
//   seqState_t    : sequencer FSM states
//   SEQ_CNT_MAX_W : widest counter needed over the full legal parameter range
//   seqCntWidth() : counter width for a given parameter pair
package ofs_plat_reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    WAIT_ENTER = 2'd1,
    WAIT_EXIT  = 2'd2,
    RUN        = 2'd3
  } seqState_t;

  // ACK_TIMEOUT_CYCLES may reach 2^20, so its last count (2^20-1) needs 20 bits.
  localparam int unsigned SEQ_CNT_MAX_W = 20;

  // $clog2 of the larger cycle limit, kept within 1..SEQ_CNT_MAX_W.
  function automatic int unsigned seqCntWidth(input int unsigned minAssert,
                                              input int unsigned ackTimeout);
    int unsigned largest;
    int unsigned w;
    largest = (minAssert > ackTimeout) ? minAssert : ackTimeout;
    w = $clog2(largest);
    if (w < 1) w = 1;
    if (w > SEQ_CNT_MAX_W) w = SEQ_CNT_MAX_W;
    return w;
  endfunction

endpackage

// File: rtl/ofs_plat_reset_seq_sync.sv
// ofs_plat_reset_seq_sync
//   Per-bit 2-flop synchronizer bringing asynchronous feedback into clk.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears both flop stages
//   asyncIn : WIDTH bits from other clock domains
//   syncOut : asyncIn delayed by two clk edges
module ofs_plat_reset_seq_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta    <= '0;
      syncOut <= '0;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end

endmodule

// File: rtl/ofs_plat_reset_release_sequencer.sv
// ofs_plat_reset_release_sequencer
//   Drives one reset to N_DOMAINS clock domains and sequences its release
//   using each domain's reset state as fed back into clk.
//   ASSERT     : reset_n_out held low for MIN_ASSERT_CYCLES cycles
//   WAIT_ENTER : reset still low until every domain reports reset
//   WAIT_EXIT  : reset released, waiting for every domain to leave reset
//   RUN        : all domains running; a request or a domain dropping resequences
//   Each wait is bounded by ACK_TIMEOUT_CYCLES; a timeout advances anyway and
//   records the offending domains in sticky error flags.
//
//   clk               : single clock
//   reset_n           : asynchronous active-low reset
//   soft_reset_req    : request for a full reset sequence
//   domain_reset_n_fb : per-domain reset_n feedback (asynchronous to clk)
//   err_clear         : clears timeout_err / timeout_domains
//   reset_n_out       : registered reset to all domains (0 = asserted)
//   all_ready         : every domain has left reset
//   busy              : sequencer is not in RUN
//   timeout_err       : sticky, a feedback wait timed out
//   timeout_domains   : sticky OR of domains that missed a wait
module ofs_plat_reset_release_sequencer
  import ofs_plat_reset_seq_pkg::*;
#(
  parameter int unsigned N_DOMAINS          = 4,
  parameter int unsigned MIN_ASSERT_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 soft_reset_req,
  input  logic [N_DOMAINS-1:0] domain_reset_n_fb,
  input  logic                 err_clear,
  output logic                 reset_n_out,
  output logic                 all_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [N_DOMAINS-1:0] timeout_domains
);

  localparam int unsigned CNT_W = seqCntWidth(MIN_ASSERT_CYCLES, ACK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(ACK_TIMEOUT_CYCLES - 1);

  seqState_t            state;
  logic [CNT_W-1:0]     cnt;
  logic                 pending;
  logic [N_DOMAINS-1:0] fbSync;

  logic                 fbAllLow;
  logic                 fbAllHigh;
  logic                 assertDone;
  logic                 waitDone;
  logic [CNT_W-1:0]     cntInc;
  logic                 timeoutHit;
  logic [N_DOMAINS-1:0] timeoutBits;

  ofs_plat_reset_seq_sync #(
    .WIDTH (N_DOMAINS)
  ) fbSyncInst (
    .clk     (clk),
    .reset_n (reset_n),
    .asyncIn (domain_reset_n_fb),
    .syncOut (fbSync)
  );

  assign fbAllLow   = (fbSync == '0);
  assign fbAllHigh  = (fbSync == '1);
  assign assertDone = (cnt == ASSERT_LAST);
  assign waitDone   = (cnt == WAIT_LAST);
  assign cntInc     = (cnt == '1) ? cnt : cnt + 1'b1;

  // A timeout is a wait reaching its last count with the condition still
  // unmet; the offending domains are those still on the wrong side.
  always_comb begin
    timeoutHit  = 1'b0;
    timeoutBits = '0;
    case (state)
      WAIT_ENTER: begin
        timeoutHit  = waitDone && !fbAllLow;
        timeoutBits = fbSync;
      end
      WAIT_EXIT: begin
        timeoutHit  = waitDone && !fbAllHigh;
        timeoutBits = ~fbSync;
      end
      default: begin
        timeoutHit  = 1'b0;
        timeoutBits = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ASSERT;
      cnt             <= '0;
      pending         <= 1'b0;
      reset_n_out     <= 1'b0;
      all_ready       <= 1'b0;
      busy            <= 1'b1;
      timeout_err     <= 1'b0;
      timeout_domains <= '0;
    end else begin
      // A timeout on the same cycle as err_clear wins, but only its own
      // domains survive the clear.
      if (timeoutHit) begin
        timeout_err     <= 1'b1;
        timeout_domains <= (err_clear ? '0 : timeout_domains) | timeoutBits;
      end else if (err_clear) begin
        timeout_err     <= 1'b0;
        timeout_domains <= '0;
      end

      case (state)
        ASSERT: begin
          if (soft_reset_req) begin
            cnt <= '0;
          end else if (assertDone) begin
            state <= WAIT_ENTER;
            cnt   <= '0;
          end else begin
            cnt <= cntInc;
          end
        end

        WAIT_ENTER: begin
          if (soft_reset_req) pending <= 1'b1;
          if (fbAllLow || waitDone) begin
            state       <= WAIT_EXIT;
            cnt         <= '0;
            reset_n_out <= 1'b1;
          end else begin
            cnt <= cntInc;
          end
        end

        WAIT_EXIT: begin
          if (fbAllHigh || waitDone) begin
            cnt <= '0;
            // A request seen anywhere in the waits, including this cycle,
            // turns the exit into a fresh sequence.
            if (pending || soft_reset_req) begin
              state       <= ASSERT;
              pending     <= 1'b0;
              reset_n_out <= 1'b0;
            end else begin
              state     <= RUN;
              busy      <= 1'b0;
              // After a timeout not every domain is out of reset.
              all_ready <= fbAllHigh;
            end
          end else begin
            if (soft_reset_req) pending <= 1'b1;
            cnt <= cntInc;
          end
        end

        RUN: begin
          if (soft_reset_req || !fbAllHigh) begin
            state       <= ASSERT;
            cnt         <= '0;
            reset_n_out <= 1'b0;
            all_ready   <= 1'b0;
            busy        <= 1'b1;
          end
        end

        default: begin
          state       <= ASSERT;
          cnt         <= '0;
          pending     <= 1'b0;
          reset_n_out <= 1'b0;
          all_ready   <= 1'b0;
          busy        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofs_plat_reset_release_sequencer.sv
// tb_ofs_plat_reset_release_sequencer
//   Directed scenarios plus randomized stimulus against a cycle-level
//   behavioural model of the reset release sequencer.
module tb_ofs_plat_reset_release_sequencer;

  localparam int N   = 4;
  localparam int MIN = 16;
  localparam int TO  = 64;

  localparam int P_HOLD  = 0;
  localparam int P_ENTER = 1;
  localparam int P_EXIT  = 2;
  localparam int P_RUN   = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         soft_reset_req = 1'b0;
  logic         err_clear = 1'b0;
  logic [N-1:0] domain_reset_n_fb = '0;
  logic         reset_n_out;
  logic         all_ready;
  logic         busy;
  logic         timeout_err;
  logic [N-1:0] timeout_domains;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ofs_plat_reset_release_sequencer #(
    .N_DOMAINS          (N),
    .MIN_ASSERT_CYCLES  (MIN),
    .ACK_TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .soft_reset_req    (soft_reset_req),
    .domain_reset_n_fb (domain_reset_n_fb),
    .err_clear         (err_clear),
    .reset_n_out       (reset_n_out),
    .all_ready         (all_ready),
    .busy              (busy),
    .timeout_err       (timeout_err),
    .timeout_domains   (timeout_domains)
  );

  // Behavioural model: phase plus cycles spent in it; feedback seen by the
  // sequencer is the sample taken two edges earlier.
  int           mPhase;
  int           mEl;
  bit           mPend;
  bit           mRo, mRdy, mBusy, mErr;
  logic [N-1:0] mDom;
  logic [N-1:0] fbQ[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mPhase = P_HOLD; mEl = 0; mPend = 0;
    mRo = 0; mRdy = 0; mBusy = 1; mErr = 0; mDom = '0;
    fbQ = {};
    fbQ.push_back('0);
    fbQ.push_back('0);
  endfunction

  function automatic void enterHold();
    mPhase = P_HOLD; mEl = 0; mRo = 0; mRdy = 0; mBusy = 1;
  endfunction

  function automatic void modelStep(input bit s, input logic [N-1:0] fb, input bit clr);
    logic [N-1:0] sy;
    bit           toHit;
    logic [N-1:0] late;
    sy = fbQ.pop_front();
    fbQ.push_back(fb);
    toHit = 0;
    late  = '0;
    case (mPhase)
      P_HOLD: begin
        if (s) mEl = 0;
        else if (mEl == MIN - 1) begin mPhase = P_ENTER; mEl = 0; end
        else mEl++;
      end
      P_ENTER: begin
        if (s) mPend = 1;
        if (sy == '0 || mEl == TO - 1) begin
          if (sy != '0) begin toHit = 1; late = sy; end
          mPhase = P_EXIT; mEl = 0; mRo = 1;
        end else mEl++;
      end
      P_EXIT: begin
        if (s) mPend = 1;
        if (sy == '1 || mEl == TO - 1) begin
          if (sy != '1) begin toHit = 1; late = ~sy; end
          if (mPend) begin mPend = 0; enterHold(); end
          else begin mPhase = P_RUN; mBusy = 0; mRdy = (sy == '1); end
        end else mEl++;
      end
      default: begin
        if (s || sy != '1) enterHold();
      end
    endcase
    if (clr) begin mErr = 0; mDom = '0; end
    if (toHit) begin mErr = 1; mDom = mDom | late; end
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit s, input logic [N-1:0] fb, input bit clr);
    soft_reset_req = s;
    domain_reset_n_fb = fb;
    err_clear = clr;
    @(posedge clk);
    modelStep(s, fb, clr);
    #1;
    checkVal("outs", 32'({reset_n_out, all_ready, busy, timeout_err, timeout_domains}),
             32'({mRo, mRdy, mBusy, mErr, mDom}));
    @(negedge clk);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    modelReset();
    #1;
    checkVal("rstState", 32'({reset_n_out, all_ready, busy, timeout_err, timeout_domains}),
             32'({1'b0, 1'b0, 1'b1, 1'b0, 4'h0}));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic lowLen(input logic [N-1:0] fb, output int n);
    n = 0;
    while (!reset_n_out && n < 300) begin cyc(0, fb, 0); n++; end
  endtask

  task automatic readyLat(output int n);
    n = 0;
    do begin cyc(0, '1, 0); n++; end while (!all_ready && n < 300);
  endtask

  initial begin
    int  n;
    bit  sawRdy;
    logic [N-1:0] fbR;

    modelReset();
    @(negedge clk);
    doReset();

    // Release timing from reset with feedback low.
    lowLen('0, n);
    checkVal("lowLen", n, 17);
    readyLat(n);
    checkVal("rdyLat", n, 3);
    checkVal("runBusy", 32'(busy), 0);

    // Soft reset from RUN and full resequence.
    cyc(1, '1, 0);
    checkVal("softOuts", 32'({reset_n_out, all_ready, busy}), 32'(3'b001));
    lowLen('0, n);
    checkVal("reseqLow", n, 17);
    readyLat(n);
    checkVal("reseqRdy", n, 3);

    // Domain 2 stuck out of reset during WAIT_ENTER.
    cyc(1, '1, 0);
    lowLen(4'h4, n);
    checkVal("toLen", n, 80);
    checkVal("toErr", 32'(timeout_err), 1);
    checkVal("toDom", 32'(timeout_domains), 32'(4'b0100));
    cyc(0, '1, 1);
    checkVal("clrErr", 32'({timeout_err, timeout_domains}), 0);
    readyLat(n);
    checkVal("toRdy", 32'(all_ready), 1);

    // Request during WAIT_EXIT: no ready, back to ASSERT, then normal.
    cyc(1, '1, 0);
    lowLen('0, n);
    cyc(1, '0, 0);
    sawRdy = 0;
    n = 0;
    while (reset_n_out && n < 20) begin
      cyc(0, '1, 0);
      sawRdy |= all_ready;
      n++;
    end
    checkVal("pendNoRdy", 32'(sawRdy), 0);
    checkVal("pendAssert", 32'({reset_n_out, busy}), 32'(2'b01));
    lowLen('0, n);
    readyLat(n);
    checkVal("pend2ndRdy", n, 3);

    // Hard reset part way through ASSERT restarts the full hold.
    cyc(1, '1, 0);
    for (int i = 0; i < 9; i++) cyc(0, '0, 0);
    doReset();
    lowLen('0, n);
    checkVal("rstMid", n, 17);
    readyLat(n);

    // A domain dropping in RUN forces a resequence.
    n = 0;
    do begin cyc(0, 4'hE, 0); n++; end while (all_ready && n < 20);
    checkVal("dropLat", n, 3);
    checkVal("dropOuts", 32'({reset_n_out, busy}), 32'(2'b01));

    // Randomized: feedback mostly follows reset_n_out, with glitches.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) doReset();
      if ($urandom_range(0, 7) == 0) fbR = N'($urandom);
      else fbR = mRo ? '1 : '0;
      cyc($urandom_range(0, 59) == 0, fbR, $urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
